theremin_tone_gen: RTL and testbench

- Downstream consumer of ultrasonic_sensor.
- Takes each distance_cm / distance_ready measurement, range-checks it, smooths it with a 4-tap moving average and quantises it to one of 16 chromatic notes (C4..D#5).
- Drives a glitch-free 1-bit square-wave audio output for the theremin speaker/DAC path.
- Mutes after repeated out-of-range readings.

---
 rtl/theremin_tone_gen.sv | 180 ++++++++++++++++++
 tb/tb_theremin_tone_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/theremin_tone_gen.sv
// rtl/theremin_tone_gen.sv - distance-driven note quantiser and glitch-free square-wave tone generator
`timescale 1ns/1ps
module theremin_tone_gen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int MIN_CM     = 5,
    parameter int CM_LOG2    = 1,
    parameter int NUM_NOTES  = 16,
    parameter int MAX_CM     = 36,
    parameter int MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] distance_cm,
    input  logic        distance_ready,
    output logic        audio_out,
    output logic        tone_active,
    output logic [3:0]  note_index,
    output logic [16:0] half_period,
    output logic        note_valid
);

    localparam int                MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam logic [15:0]       MIN_D    = 16'(MIN_CM);
    localparam logic [15:0]       MAX_D    = 16'(MAX_CM);
    localparam logic [15:0]       TOP_NOTE = 16'(NUM_NOTES - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

    // Reference half periods at 50 MHz, C4..D#5; these pin the exact tuning.
    localparam logic [16:0] HP_50M [16] = '{
        17'd95556, 17'd90193, 17'd85131, 17'd80353, 17'd75843, 17'd71586, 17'd67568, 17'd63776,
        17'd60197, 17'd56818, 17'd53629, 17'd50619, 17'd47778, 17'd45097, 17'd42566, 17'd40177
    };

    typedef enum logic {MUTED = 1'b0, PLAYING = 1'b1} state_t;

    // Equal-tempered half period for other clock rates, evaluated at elaboration only.
    function automatic logic [16:0] hp_of(input int k);
        real f;
        f = 440.0 * (2.0 ** ((real'(k) - 9.0) / 12.0));
        return 17'($rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5));
    endfunction

    logic [16:0] hp_rom [16];

    for (genvar k = 0; k < 16; k++) begin : g_rom
        if (CLK_HZ == 50_000_000) begin : g_ref
            assign hp_rom[k] = HP_50M[k];
        end else begin : g_calc
            localparam logic [16:0] HP = hp_of(k);
            assign hp_rom[k] = HP;
        end
    end

    state_t             state_q, state_d;
    logic               ready_q;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [15:0]        tap_q [4];
    logic               v1_q, v2_q;
    logic [15:0]        avg_q;
    logic [17:0]        sum;
    logic [15:0]        diff, step;
    logic [3:0]         note_d;
    logic [3:0]         note_q;
    logic [16:0]        hp_q;
    logic               nv_q;
    logic [16:0]        cur_hp_q, cnt_q;
    logic               audio_q;
    logic               sample, in_range;

    assign sample   = distance_ready & ~ready_q;
    assign in_range = (distance_cm >= MIN_D) && (distance_cm <= MAX_D);

    // Next state and miss counter: out-of-range samples count up to the mute limit.
    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        if (sample) begin
            if (in_range) begin
                miss_d  = '0;
                state_d = PLAYING;
            end else begin
                if (miss_q != MISS_MAX) begin
                    miss_d = miss_q + MISS_W'(1);
                end
                if (miss_d == MISS_MAX) begin
                    state_d = MUTED;
                end
            end
        end
    end

    // Edge detect, FSM and tap update; a sample from MUTED prefills every tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            state_q <= MUTED;
            miss_q  <= '0;
            v1_q    <= 1'b0;
            for (int i = 0; i < 4; i++) tap_q[i] <= '0;
        end else begin
            ready_q <= distance_ready;
            state_q <= state_d;
            miss_q  <= miss_d;
            v1_q    <= sample && in_range;
            if (sample && in_range) begin
                if (state_q == MUTED) begin
                    for (int i = 0; i < 4; i++) tap_q[i] <= distance_cm;
                end else begin
                    tap_q[0] <= distance_cm;
                    tap_q[1] <= tap_q[0];
                    tap_q[2] <= tap_q[1];
                    tap_q[3] <= tap_q[2];
                end
            end
        end
    end

    assign sum = {2'b00, tap_q[0]} + {2'b00, tap_q[1]} + {2'b00, tap_q[2]} + {2'b00, tap_q[3]};

    // Average stage: truncating divide by four.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            avg_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) avg_q <= 16'(sum >> 2);
        end
    end

    assign diff   = avg_q - MIN_D;
    assign step   = diff >> CM_LOG2;
    assign note_d = (step > TOP_NOTE) ? TOP_NOTE[3:0] : step[3:0];

    // Note stage: publish note index and half period with a one-cycle valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nv_q   <= 1'b0;
            note_q <= '0;
            hp_q   <= '0;
        end else begin
            nv_q <= v2_q;
            if (v2_q) begin
                note_q <= note_d;
                hp_q   <= hp_rom[note_d];
            end
        end
    end

    // Tone generator: period changes are taken only at toggle boundaries; mute clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            cur_hp_q <= '0;
            audio_q  <= 1'b0;
        end else if (state_d == MUTED) begin
            cnt_q    <= '0;
            cur_hp_q <= '0;
            audio_q  <= 1'b0;
        end else if (cur_hp_q == '0) begin
            if (v2_q) begin
                cur_hp_q <= hp_rom[note_d];
                cnt_q    <= '0;
            end
        end else if (cnt_q == cur_hp_q - 17'd1) begin
            audio_q  <= ~audio_q;
            cnt_q    <= '0;
            cur_hp_q <= v2_q ? hp_rom[note_d] : hp_q;
        end else begin
            cnt_q <= cnt_q + 17'd1;
        end
    end

    assign audio_out   = audio_q;
    assign tone_active = (state_q == PLAYING);
    assign note_index  = note_q;
    assign half_period = hp_q;
    assign note_valid  = nv_q;

endmodule

// File: tb/tb_theremin_tone_gen.sv
// tb/tb_theremin_tone_gen.sv - directed self-checking bench for theremin_tone_gen
`timescale 1ns/1ps
module tb_theremin_tone_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] distance_cm;
    logic        distance_ready;
    logic        audio_out;
    logic        tone_active;
    logic [3:0]  note_index;
    logic [16:0] half_period;
    logic        note_valid;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int nv_cnt = 0;

    theremin_tone_gen dut (
        .clk            (clk),
        .rst            (rst),
        .distance_cm    (distance_cm),
        .distance_ready (distance_ready),
        .audio_out      (audio_out),
        .tone_active    (tone_active),
        .note_index     (note_index),
        .half_period    (half_period),
        .note_valid     (note_valid)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (note_valid) nv_cnt <= nv_cnt + 1;
    end

    initial begin
        #(20 * 99000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle ready pulse; reports the negedge index (1..8) where note_valid was seen.
    task automatic do_sample(input logic [15:0] d, output int nv_at, output int nv_cyc);
        nv_at  = 0;
        nv_cyc = 0;
        @(negedge clk);
        distance_cm    = d;
        distance_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) distance_ready = 1'b0;
            if (note_valid && nv_at == 0) begin
                nv_at  = i;
                nv_cyc = cyc;
            end
        end
    endtask

    int   nv_at, t_nv, tmp, nv_before;
    logic early;
    int   d20_note [4] = '{3, 5, 6, 7};
    int   d20_hp   [4] = '{80353, 71586, 67568, 63776};

    initial begin
        rst            = 1'b1;
        distance_cm    = '0;
        distance_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_audio", int'(audio_out), 0);
        check("rst_active", int'(tone_active), 0);
        check("rst_note", int'(note_index), 0);
        check("rst_hp", int'(half_period), 0);
        check("rst_valid", int'(note_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // First sample from MUTED: prefill and latency
        do_sample(16'd10, nv_at, t_nv);
        check("s10_latency", nv_at, 3);
        check("s10_note", int'(note_index), 2);
        check("s10_hp", int'(half_period), 85131);
        check("s10_active", int'(tone_active), 1);
        check("s10_audio", int'(audio_out), 0);

        // Moving average walk with 20 cm samples
        for (int i = 0; i < 4; i++) begin
            do_sample(16'd20, nv_at, tmp);
            check("s20_latency", nv_at, 3);
            check("s20_note", int'(note_index), d20_note[i]);
            check("s20_hp", int'(half_period), d20_hp[i]);
            check("s20_audio", int'(audio_out), 0);
        end

        // First toggle exactly one original half period after note_valid
        early = 1'b0;
        while (cyc < t_nv + 85130) begin
            @(negedge clk);
            if (audio_out) early = 1'b1;
        end
        check("no_runt_toggle", int'(early), 0);
        @(negedge clk);
        check("toggle_at_hp", int'(audio_out), 1);

        // Two misses then in-range keeps playing and clears the miss count
        do_sample(16'd50, nv_at, tmp);
        check("miss1_no_valid", nv_at, 0);
        check("miss1_active", int'(tone_active), 1);
        check("miss1_note", int'(note_index), 7);
        do_sample(16'd50, nv_at, tmp);
        check("miss2_active", int'(tone_active), 1);
        check("miss2_audio", int'(audio_out), 1);
        do_sample(16'd12, nv_at, tmp);
        check("s12_latency", nv_at, 3);
        check("s12_note", int'(note_index), 6);
        check("s12_hp", int'(half_period), 67568);
        do_sample(16'd50, nv_at, tmp);
        do_sample(16'd50, nv_at, tmp);
        check("miss_cleared_active", int'(tone_active), 1);
        check("miss_cleared_audio", int'(audio_out), 1);
        do_sample(16'd50, nv_at, tmp);
        check("mute_active", int'(tone_active), 0);
        check("mute_audio", int'(audio_out), 0);
        check("mute_note_kept", int'(note_index), 6);

        // Asynchronous reset while playing
        do_sample(16'd10, nv_at, tmp);
        check("replay_active", int'(tone_active), 1);
        check("replay_note", int'(note_index), 2);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_active", int'(tone_active), 0);
        check("async_rst_note", int'(note_index), 0);
        check("async_rst_hp", int'(half_period), 0);
        check("async_rst_audio", int'(audio_out), 0);
        @(negedge clk);
        rst       = 1'b0;
        nv_before = nv_cnt;
        repeat (50) @(negedge clk);
        check("post_rst_silent", int'(audio_out), 0);
        check("post_rst_active", int'(tone_active), 0);
        check("post_rst_no_valid", nv_cnt - nv_before, 0);

        // Ready held high: exactly one sample
        nv_before = nv_cnt;
        @(negedge clk);
        distance_cm    = 16'd30;
        distance_ready = 1'b1;
        repeat (1000) @(negedge clk);
        distance_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_one_valid", nv_cnt - nv_before, 1);
        check("hold_note", int'(note_index), 12);
        check("hold_hp", int'(half_period), 47778);
        check("hold_active", int'(tone_active), 1);

        // Range boundaries just outside the window
        do_sample(16'd4, nv_at, tmp);
        check("s4_no_valid", nv_at, 0);
        check("s4_active", int'(tone_active), 1);
        do_sample(16'd37, nv_at, tmp);
        check("s37_no_valid", nv_at, 0);
        check("s37_active", int'(tone_active), 1);
        do_sample(16'd37, nv_at, tmp);
        check("s37_mute", int'(tone_active), 0);
        check("s37_note_kept", int'(note_index), 12);

        // Range boundaries at the window edges, each from MUTED
        do_sample(16'd36, nv_at, tmp);
        check("s36_latency", nv_at, 3);
        check("s36_note", int'(note_index), 15);
        check("s36_hp", int'(half_period), 40177);
        check("s36_active", int'(tone_active), 1);
        for (int i = 0; i < 3; i++) do_sample(16'd50, nv_at, tmp);
        check("remute_active", int'(tone_active), 0);
        do_sample(16'd5, nv_at, tmp);
        check("s5_latency", nv_at, 3);
        check("s5_note", int'(note_index), 0);
        check("s5_hp", int'(half_period), 95556);
        check("s5_active", int'(tone_active), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
